// File: rtl/pingpang_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pingpang_pkg
//  Purpose  : Shared helpers for the N-bank ping-pong frame buffer:
//             - clog2      : constant-foldable ceiling log2 used for widths
//             - next_bank  : bank-pointer increment with wrap NUM_BANKS-1 -> 0
//             - DEF_*      : default configuration values
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pingpang_pkg;

    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_DEPTH     = 64;
    localparam int unsigned DEF_NUM_BANKS = 2;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 1) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Bank pointers are carried at 32 bits here and truncated by the caller,
    // so one function serves any pointer width.
    function automatic logic [31:0] next_bank(input logic [31:0] bank,
                                              input logic [31:0] num_banks);
        return (bank == num_banks - 32'd1) ? 32'd0 : bank + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram_ar.sv
`default_nettype none
// ============================================================================
//  Module   : sdp_ram_ar
//  Purpose  : Simple dual-port RAM, synchronous write, asynchronous read.
//  Ports    : clk      in   1        write clock
//             i_we     in   1        write enable
//             i_waddr  in   ADDR_W   write address
//             i_wdata  in   DATA_W   write data
//             i_raddr  in   ADDR_W   read address
//             o_rdata  out  DATA_W   read data (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module sdp_ram_ar
    import pingpang_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]         o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pingpong_nbank_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_nbank_buf
//  Purpose  : Parametrised N-bank ping-pong frame buffer. Upstream fills one
//             bank while downstream drains committed banks in FIFO order.
//             A bank commits when it is full or when i_last accompanies a
//             word; it is released when its final word enters the output
//             register.
//  Ports    : sys_clk             in   1       clock
//             sys_rst_n           in   1       async reset, active low
//             data_en             in   1       upstream valid
//             data_in             in   DATA_W  upstream data
//             i_last              in   1       close current bank after word
//             o_upstream_ready    out  1       write bank available
//             i_downstream_ready  in   1       downstream ready
//             o_downstream_valid  out  1       output register holds a word
//             data_out            out  DATA_W  output register data
//             o_last              out  1       data_out ends its frame
//             o_full_cnt          out  CNT_W   committed, unreleased banks
//             o_drop_err          out  1       sticky: write while not ready
//  Revision : 1.0  initial release
// ============================================================================
module pingpong_nbank_buf
    import pingpang_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned NUM_BANKS = DEF_NUM_BANKS
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               data_en,
    input  logic [DATA_W-1:0]                  data_in,
    input  logic                               i_last,
    output logic                               o_upstream_ready,
    input  logic                               i_downstream_ready,
    output logic                               o_downstream_valid,
    output logic [DATA_W-1:0]                  data_out,
    output logic                               o_last,
    output logic [clog2(NUM_BANKS+1)-1:0]      o_full_cnt,
    output logic                               o_drop_err
);

    localparam int unsigned c_ADDR_W = clog2(DEPTH);
    localparam int unsigned c_BANK_W = clog2(NUM_BANKS);
    localparam int unsigned c_CNT_W  = clog2(NUM_BANKS + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_BANK_W-1:0] r_wr_bank;
    logic [c_ADDR_W-1:0] r_wr_addr;
    logic [c_BANK_W-1:0] r_rd_bank;
    logic [c_ADDR_W-1:0] r_rd_addr;
    logic [c_CNT_W-1:0]  r_full_cnt;
    // Each bank stores the index of its final word (frame length - 1), which
    // keeps the entry at ADDR_W bits and makes the last-word test a compare.
    logic [c_ADDR_W-1:0] r_last_idx [NUM_BANKS];
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic                r_last;
    logic                r_drop_err;

    // ------------------------------------------------------------------
    // Handshake / control decode
    // ------------------------------------------------------------------
    logic                w_up_ready;
    logic                w_wr_hs;
    logic                w_commit;
    logic                w_load;
    logic                w_rd_is_last;
    logic                w_release;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_bank_rdata [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_bank_we;

    assign w_up_ready   = (r_full_cnt < c_CNT_W'(NUM_BANKS));
    assign w_wr_hs      = data_en & w_up_ready;
    assign w_commit     = w_wr_hs & (i_last | (r_wr_addr == c_ADDR_W'(DEPTH - 1)));
    assign w_load       = (r_full_cnt != '0) & (~r_valid | i_downstream_ready);
    assign w_rd_is_last = (r_rd_addr == r_last_idx[r_rd_bank]);
    assign w_release    = w_load & w_rd_is_last;
    assign w_rd_data    = w_bank_rdata[r_rd_bank];

    // ------------------------------------------------------------------
    // Bank storage: one RAM per bank, write enable decoded from wr_bank
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign w_bank_we[g] = w_wr_hs & (r_wr_bank == c_BANK_W'(g));

        sdp_ram_ar #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk     (sys_clk),
            .i_we    (w_bank_we[g]),
            .i_waddr (r_wr_addr),
            .i_wdata (data_in),
            .i_raddr (r_rd_addr),
            .o_rdata (w_bank_rdata[g])
        );
    end

    // ------------------------------------------------------------------
    // Write side: address advance, commit, length capture
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_bank <= '0;
            r_wr_addr <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                r_last_idx[b] <= '0;
            end
        end else if (w_wr_hs) begin
            if (w_commit) begin
                r_last_idx[r_wr_bank] <= r_wr_addr;
                r_wr_addr             <= '0;
                r_wr_bank             <= c_BANK_W'(next_bank(32'(r_wr_bank), NUM_BANKS));
            end else begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: output register load, pointer advance, release
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_bank <= '0;
            r_rd_addr <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_rd_data;
            r_last  <= w_rd_is_last;
            r_valid <= 1'b1;
            // The bank is handed back as soon as its last word is in the
            // output register, not when downstream accepts it.
            if (w_rd_is_last) begin
                r_rd_addr <= '0;
                r_rd_bank <= c_BANK_W'(next_bank(32'(r_rd_bank), NUM_BANKS));
            end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end else if (i_downstream_ready & r_valid) begin
            r_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy and sticky drop flag
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_full_cnt <= '0;
            r_drop_err <= 1'b0;
        end else begin
            // Commit and release in the same cycle cancel out.
            if (w_commit && !w_release) begin
                r_full_cnt <= r_full_cnt + 1'b1;
            end else if (!w_commit && w_release) begin
                r_full_cnt <= r_full_cnt - 1'b1;
            end
            if (data_en && !w_up_ready) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign o_upstream_ready   = w_up_ready;
    assign o_downstream_valid = r_valid;
    assign data_out           = r_data;
    assign o_last             = r_last;
    assign o_full_cnt         = r_full_cnt;
    assign o_drop_err         = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_nbank_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pingpong_nbank_buf
//  Purpose  : Self-checking bench. Two DUT configurations share stimulus:
//             A = 2 banks x 64 words, B = 4 banks x 16 words. `sel` picks
//             which one the frame-queue model follows and checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pingpong_nbank_buf;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        data_en   = 1'b0;
    logic [63:0] data_in   = '0;
    logic        i_last    = 1'b0;
    logic        ds_ready  = 1'b0;
    logic        sel       = 1'b0;

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- DUT A: 2 x 64 ----------------
    logic        a_ready, a_valid, a_last, a_err;
    logic [63:0] a_data;
    logic [1:0]  a_fcnt;

    pingpong_nbank_buf #(.DATA_W(64), .DEPTH(64), .NUM_BANKS(2)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .data_en(data_en), .data_in(data_in), .i_last(i_last),
        .o_upstream_ready(a_ready), .i_downstream_ready(ds_ready),
        .o_downstream_valid(a_valid), .data_out(a_data), .o_last(a_last),
        .o_full_cnt(a_fcnt), .o_drop_err(a_err)
    );

    // ---------------- DUT B: 4 x 16 ----------------
    logic        b_ready, b_valid, b_last, b_err;
    logic [63:0] b_data;
    logic [2:0]  b_fcnt;

    pingpong_nbank_buf #(.DATA_W(64), .DEPTH(16), .NUM_BANKS(4)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .data_en(data_en), .data_in(data_in), .i_last(i_last),
        .o_upstream_ready(b_ready), .i_downstream_ready(ds_ready),
        .o_downstream_valid(b_valid), .data_out(b_data), .o_last(b_last),
        .o_full_cnt(b_fcnt), .o_drop_err(b_err)
    );

    logic        act_ready, act_valid, act_last, act_err;
    logic [63:0] act_data;
    logic [3:0]  act_fcnt;
    assign act_ready = sel ? b_ready : a_ready;
    assign act_valid = sel ? b_valid : a_valid;
    assign act_last  = sel ? b_last  : a_last;
    assign act_err   = sel ? b_err   : a_err;
    assign act_data  = sel ? b_data  : a_data;
    assign act_fcnt  = sel ? {1'b0, b_fcnt} : {2'b00, a_fcnt};

    // ---------------- Behavioural model: queues of frames ----------------
    int          m_depth = 64;
    int          m_nb    = 2;
    logic [64:0] m_cq[$];      // committed words, {last, data}, FIFO order
    logic [63:0] m_pq[$];      // words of the frame still being written
    int          m_full  = 0;  // committed frames not yet handed back
    logic        m_valid = 1'b0;
    logic        m_last  = 1'b0;
    logic        m_err   = 1'b0;
    logic [63:0] m_data  = '0;

    task automatic model_reset();
        m_depth = sel ? 16 : 64;
        m_nb    = sel ? 4 : 2;
        m_cq.delete();
        m_pq.delete();
        m_full  = 0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
    endtask

    task automatic model_step();
        bit          rdy, hs, ld, lst;
        logic [64:0] w;
        rdy = (m_full < m_nb);
        hs  = data_en && rdy;
        ld  = (m_full > 0) && (!m_valid || ds_ready);
        if (data_en && !rdy) m_err = 1'b1;
        if (ld) begin
            w       = m_cq.pop_front();
            m_data  = w[63:0];
            m_last  = w[64];
            m_valid = 1'b1;
            if (w[64]) m_full--;
        end else if (ds_ready && m_valid) begin
            m_valid = 1'b0;
        end
        if (hs) begin
            m_pq.push_back(data_in);
            if (m_pq.size() == m_depth || i_last) begin
                foreach (m_pq[k]) begin
                    lst = (k == m_pq.size() - 1);
                    m_cq.push_back({lst, m_pq[k]});
                end
                m_pq.delete();
                m_full++;
            end
        end
    endtask

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) model_reset();
        else            model_step();
    end

    // ---------------- Per-cycle compare + consumption log ----------------
    logic [64:0] obs[$];

    always @(negedge sys_clk) begin
        logic       exp_ready;
        logic [3:0] exp_cnt;
        exp_ready = (m_full < m_nb);
        exp_cnt   = 4'(m_full);
        n_vec++;
        if (act_ready !== exp_ready || act_valid !== m_valid || act_data !== m_data ||
            act_last !== m_last || act_fcnt !== exp_cnt || act_err !== m_err) begin
            n_err++;
            $display("FAIL cycle t=%0t (actual/required) ready %b/%b valid %b/%b data %h/%h last %b/%b cnt %0d/%0d err %b/%b",
                     $time, act_ready, exp_ready, act_valid, m_valid, act_data, m_data,
                     act_last, m_last, act_fcnt, exp_cnt, act_err, m_err);
        end
        if (sys_rst_n && act_valid && ds_ready) obs.push_back({act_last, act_data});
    end

    // ---------------- Helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        data_en  = 1'b0;
        i_last   = 1'b0;
        ds_ready = 1'b0;
        sel      = s;
        #2;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        obs.delete();
    endtask

    task automatic send(input logic [63:0] d, input logic lst);
        int guard;
        guard = 0;
        while (!act_ready && guard < 2000) begin
            tick();
            guard++;
        end
        if (!act_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send-timeout: ready stayed %b, required 1", act_ready);
        end else begin
            data_en = 1'b1;
            data_in = d;
            i_last  = lst;
            tick();
            data_en = 1'b0;
            i_last  = 1'b0;
        end
    endtask

    task automatic wait_obs(input int n, input int budget);
        int c;
        c = 0;
        while (obs.size() < n && c < budget) begin
            tick();
            c++;
        end
        check("obs_count", 64'(obs.size()), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // ---------------- Stimulus ----------------
    initial begin
        logic [64:0] w;
        int          sent, consumed, gaps_up, gaps_dn, cyc, bad, max_cnt, stall_bad;
        bit          started, pv, pr, pl;
        logic [63:0] pd;

        void'($urandom(32'd2024));

        // 1. Reset state, full 64-word frame, latency and ordering
        do_reset(1'b0);
        check("rst_ready", act_ready, 1);
        check("rst_valid", act_valid, 0);
        check("rst_data",  act_data,  0);
        check("rst_last",  act_last,  0);
        check("rst_cnt",   act_fcnt,  0);
        check("rst_err",   act_err,   0);
        ds_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(64'(i), 1'b0);
        check("t1_cnt_after_commit", act_fcnt, 1);
        check("t1_valid_at_commit",  act_valid, 0);
        tick();
        check("t1_valid_next_edge", act_valid, 1);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (act_data !== 64'(i) || act_last !== (i == 63)) bad++;
            tick();
        end
        check("t1_seq_errors", 64'(bad), 0);
        check("t1_valid_end", act_valid, 0);
        check("t1_cnt_end",   act_fcnt,  0);

        // 2. Short frame (3 words) then full frame
        do_reset(1'b0);
        ds_ready = 1'b1;
        for (int i = 0; i < 3; i++)  send(64'(100 + i), i == 2);
        for (int i = 0; i < 64; i++) send(64'(200 + i), 1'b0);
        wait_obs(67, 500);
        if (obs.size() >= 67) begin
            w = obs[0];  check("t2_w0",      w, {1'b0, 64'd100});
            w = obs[1];  check("t2_w1_last", w[64], 0);
            w = obs[2];  check("t2_w2",      w, {1'b1, 64'd102});
            w = obs[3];  check("t2_w3",      w, {1'b0, 64'd200});
            w = obs[66]; check("t2_w66",     w, {1'b1, 64'd263});
        end

        // 3. Fill both banks with downstream stalled, then force a drop
        do_reset(1'b0);
        ds_ready = 1'b0;
        for (int i = 0; i < 128; i++) send(64'(i), 1'b0);
        check("t3_cnt_full",  act_fcnt,  2);
        check("t3_ready_low", act_ready, 0);
        data_en = 1'b1;
        data_in = 64'd128;
        tick();
        data_en = 1'b0;
        check("t3_drop_err",  act_err,   1);
        check("t3_held_valid", act_valid, 1);
        check("t3_held_data",  act_data,  0);
        ds_ready = 1'b1;
        wait_obs(128, 400);
        repeat (3) tick();
        check("t3_obs_final", 64'(obs.size()), 128);
        check("t3_cnt_end",   act_fcnt, 0);
        check("t3_ready_end", act_ready, 1);
        if (obs.size() >= 128) begin
            w = obs[63];  check("t3_w63",  w, {1'b1, 64'd63});
            w = obs[64];  check("t3_w64",  w, {1'b0, 64'd64});
            w = obs[127]; check("t3_w127", w, {1'b1, 64'd127});
        end

        // 4. Ten back-to-back frames at one word per clock
        do_reset(1'b0);
        ds_ready = 1'b1;
        sent = 0; consumed = 0; gaps_up = 0; gaps_dn = 0; cyc = 0; started = 1'b0;
        data_en = 1'b1;
        data_in = '0;
        while (consumed < 640 && cyc < 3000) begin
            @(negedge sys_clk);
            if (data_en) begin
                if (act_ready) sent++;
                else           gaps_up++;
            end
            if (act_valid) begin
                started = 1'b1;
                consumed++;
            end else if (started) begin
                gaps_dn++;
            end
            @(posedge sys_clk);
            #1;
            cyc++;
            data_en = (sent < 640);
            data_in = 64'(sent);
        end
        data_en = 1'b0;
        check("t4_consumed",  64'(consumed), 640);
        check("t4_gaps_up",   64'(gaps_up), 0);
        check("t4_gaps_down", 64'(gaps_dn), 0);
        repeat (2) tick();
        bad = 0;
        foreach (obs[i]) if (obs[i] !== {(i % 64) == 63, 64'(i)}) bad++;
        check("t4_order_errors", 64'(bad), 0);

        // 5. Random handshakes on the 4 x 16 configuration
        do_reset(1'b1);
        max_cnt = 0; stall_bad = 0;
        for (int c = 0; c < 3000; c++) begin
            ds_ready = ($urandom_range(0, 2) != 0);
            data_en  = act_ready && ($urandom_range(0, 2) != 0);
            data_in  = {$urandom, $urandom};
            i_last   = ($urandom_range(0, 7) == 0);
            pv = act_valid; pr = ds_ready; pd = act_data; pl = act_last;
            tick();
            if (pv && !pr && (act_valid !== 1'b1 || act_data !== pd || act_last !== pl)) stall_bad++;
            if (int'(act_fcnt) > max_cnt) max_cnt = int'(act_fcnt);
        end
        data_en = 1'b0;
        i_last  = 1'b0;
        ds_ready = 1'b1;
        repeat (100) tick();
        check("t5_cnt_over_4", 64'(max_cnt > 4), 0);
        check("t5_stall_errs", 64'(stall_bad), 0);
        check("t5_drained",    act_fcnt, 0);

        // 6. Asynchronous reset in the middle of a drain
        do_reset(1'b0);
        ds_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(64'(1000 + i), 1'b0);
        begin
            int c6;
            c6 = 0;
            while (obs.size() < 10 && c6 < 200) begin tick(); c6++; end
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", act_valid, 0);
        check("t6_rst_data",  act_data,  0);
        check("t6_rst_last",  act_last,  0);
        check("t6_rst_cnt",   act_fcnt,  0);
        check("t6_rst_ready", act_ready, 1);
        repeat (2) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        obs.delete();
        tick();
        for (int i = 0; i < 5; i++) send(64'(2000 + i), i == 4);
        wait_obs(5, 200);
        if (obs.size() >= 5) begin
            w = obs[0]; check("t6_first", w, {1'b0, 64'd2000});
            w = obs[4]; check("t6_last",  w, {1'b1, 64'd2004});
        end
        repeat (3) tick();
        check("t6_cnt_end", act_fcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
